// File: rtl/preg_free_list.sv
// Physical-register free pool: circular FIFO of free tags, one alloc and one release per cycle.
// Optional double-free detection is enabled by defining PREG_FREE_LIST_DOUBLE_FREE_CHECK_EN.
module preg_free_list #(
    parameter int NUM_PREGS = 64,
    parameter int NUM_ARCH  = 32,
    parameter int TAG_W     = 6,
    parameter int DEPTH     = NUM_PREGS - NUM_ARCH,
    localparam int PTR_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    output logic             alloc_valid,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             rel_valid,
    input  logic [TAG_W-1:0] rel_tag,
    output logic             rel_err,
    output logic [CNT_W-1:0] free_count,
    output logic             empty,
    output logic             full
);

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             err_q;
    logic             alloc_fire;
    logic             rel_ok;
    logic             rel_drop;
    logic             double_free;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign alloc_valid = (count != '0);
    assign alloc_tag   = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign free_count  = count;
    assign rel_err     = err_q;
    assign alloc_fire  = alloc_req && alloc_valid;

`ifdef PREG_FREE_LIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PREGS-1:0] is_free;

    // A tag leaving the pool this very cycle may legally come straight back.
    assign double_free = is_free[rel_tag] && !(alloc_fire && (alloc_tag == rel_tag));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_PREGS; i++) begin
                is_free[i] <= (i >= NUM_ARCH);
            end
        end else begin
            if (alloc_fire) is_free[alloc_tag] <= 1'b0;
            if (rel_ok)     is_free[rel_tag]   <= 1'b1;
        end
    end
`else
    assign double_free = 1'b0;
`endif

    // Tag 0 is x0 and never returns to the pool; it is dropped without an error.
    assign rel_ok   = rel_valid && (rel_tag != '0) && (!full || alloc_fire) && !double_free;
    assign rel_drop = rel_valid && (rel_tag != '0) && !rel_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= CNT_W'(DEPTH);
            err_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= TAG_W'(NUM_ARCH + i);
            end
        end else begin
            err_q <= rel_drop;
            if (alloc_fire) rd_ptr <= next_ptr(rd_ptr);
            if (rel_ok) begin
                mem[wr_ptr] <= rel_tag;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            case ({rel_ok, alloc_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: queue-based reference model plus directed literal checks.
module tb_preg_free_list;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_valid;
    logic [5:0] alloc_tag;
    logic       rel_valid = 1'b0;
    logic [5:0] rel_tag = '0;
    logic       rel_err;
    logic [5:0] free_count;
    logic       empty;
    logic       full;

    int checks = 0;
    int errors = 0;

    int q[$];
    int held[$];
    bit mfree[64];
    bit merr;

    preg_free_list dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_valid(alloc_valid), .alloc_tag(alloc_tag),
        .rel_valid(rel_valid), .rel_tag(rel_tag), .rel_err(rel_err),
        .free_count(free_count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        held.delete();
        for (int i = 32; i < 64; i++) q.push_back(i);
        for (int i = 0; i < 64; i++) mfree[i] = (i >= 32);
        merr = 1'b0;
    endfunction

    task automatic compare();
        chk("alloc_valid", alloc_valid, int'(q.size() != 0));
        if (q.size() != 0) chk("alloc_tag", alloc_tag, q[0]);
        chk("free_count", free_count, q.size());
        chk("empty", empty, int'(q.size() == 0));
        chk("full", full, int'(q.size() == DEPTH));
        chk("rel_err", rel_err, merr);
    endtask

    task automatic cyc(input bit req, input bit rv, input int tag, input bit rs);
        bit fire, ok, dup;
        int head;
        alloc_req = req;
        rel_valid = rv;
        rel_tag   = 6'(tag);
        rst       = rs;
        @(negedge clk);
        compare();
        fire = req && (q.size() != 0);
        head = (q.size() != 0) ? q[0] : -1;
        dup  = 1'b0;
`ifdef PREG_FREE_LIST_DOUBLE_FREE_CHECK_EN
        dup = mfree[tag] && !(fire && head == tag);
`endif
        ok = rv && (tag != 0) && (q.size() != DEPTH || fire) && !dup;
        if (rs) begin
            model_reset();
        end else begin
            if (fire) begin
                void'(q.pop_front());
                mfree[head] = 1'b0;
                held.push_back(head);
            end
            if (ok) begin
                q.push_back(tag);
                mfree[tag] = 1'b1;
            end
            merr = rv && (tag != 0) && !ok;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int tag;
        @(posedge clk);
        #1;
        model_reset();
        cyc(0, 0, 0, 1);

        // Reset state
        chk("rst_alloc_tag", alloc_tag, 32);
        chk("rst_free_count", free_count, 32);
        chk("rst_full", full, 1);
        chk("rst_empty", empty, 0);
        chk("rst_alloc_valid", alloc_valid, 1);
        chk("rst_rel_err", rel_err, 0);

        // Drain the pool in order
        for (int i = 0; i < 32; i++) begin
            chk("drain_tag", alloc_tag, 32 + i);
            cyc(1, 0, 0, 0);
        end
        chk("drain_count", free_count, 0);
        chk("drain_empty", empty, 1);
        chk("drain_valid", alloc_valid, 0);

        // Release into empty: no bypass
        cyc(1, 1, 40, 0);
        chk("nobypass_valid", alloc_valid, 1);
        chk("nobypass_tag", alloc_tag, 40);
        chk("nobypass_count", free_count, 1);

        // Full with simultaneous alloc and release
        cyc(0, 0, 0, 1);
        chk("fullswap_tag", alloc_tag, 32);
        cyc(1, 1, 5, 0);
        chk("fullswap_count", free_count, 32);
        for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0);
        chk("fullswap_head", alloc_tag, 5);

        // Release while full is dropped; tag 0 is ignored silently
        cyc(0, 0, 0, 1);
        cyc(0, 1, 7, 0);
        chk("drop_err", rel_err, 1);
        chk("drop_count", free_count, 32);
        cyc(0, 0, 0, 0);
        chk("drop_err_pulse", rel_err, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        chk("zero_err", rel_err, 0);
        chk("zero_count", free_count, 31);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 200; i++) begin
            if (held.size() != 0 && $urandom_range(0, 99) < 70)
                tag = held[$urandom_range(0, held.size() - 1)];
            else
                tag = $urandom_range(0, 63);
            cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 55, tag, i == 100);
            if (i == 100) begin
                chk("midrst_tag", alloc_tag, 32);
                chk("midrst_count", free_count, 32);
                held.delete();
            end
        end

`ifdef PREG_FREE_LIST_DOUBLE_FREE_CHECK_EN
        cyc(0, 0, 0, 1);
        chk("df_tag", alloc_tag, 32);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 32, 0);
        chk("df_count1", free_count, 32);
        cyc(0, 1, 32, 0);
        chk("df_err1", rel_err, 1);
        chk("df_count2", free_count, 32);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 1, 33, 0);
        chk("df_count3", free_count, 31);
        cyc(0, 1, 33, 0);
        chk("df_err2", rel_err, 1);
        chk("df_count4", free_count, 31);
`endif

        cyc(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
